// File: rtl/net_perf_window_monitor.sv
// Windowed multi-channel TX/RX throughput, TX error and connection-open monitor.
// Counts handshake strobes over a programmable cycle window and publishes an atomic snapshot.
module net_perf_window_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int LEN_W  = 16,
  parameter int EVT_W  = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cfg_en,
  input  logic                      cfg_mode,
  input  logic [31:0]               cfg_window,
  input  logic                      cfg_clear,
  input  logic [NUM_CH-1:0]         tx_fire,
  input  logic [NUM_CH-1:0]         tx_err,
  input  logic [NUM_CH*LEN_W-1:0]   tx_len,
  input  logic [NUM_CH-1:0]         rx_fire,
  input  logic [NUM_CH*LEN_W-1:0]   rx_len,
  input  logic                      open_req_fire,
  input  logic                      open_ok_fire,
  output logic                      running,
  output logic [31:0]               win_cycle,
  output logic                      snap_valid,
  output logic [15:0]               snap_seq,
  output logic [NUM_CH*CNT_W-1:0]   snap_tx_bytes,
  output logic [NUM_CH*CNT_W-1:0]   snap_rx_bytes,
  output logic [NUM_CH*EVT_W-1:0]   snap_tx_err,
  output logic [EVT_W-1:0]          snap_open_req,
  output logic [EVT_W-1:0]          snap_open_ok
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0] win_len;
  logic [31:0] len_eff;
  logic [31:0] cur_idx;
  logic [31:0] cur_len;
  logic        any_fire;
  logic        trig;
  logic        active;
  logic        win_last;
  logic        count_en;
  logic        win_end;

  logic [CNT_W-1:0] acc_tx     [NUM_CH];
  logic [CNT_W-1:0] acc_rx     [NUM_CH];
  logic [EVT_W-1:0] acc_err    [NUM_CH];
  logic [CNT_W-1:0] acc_tx_nxt [NUM_CH];
  logic [CNT_W-1:0] acc_rx_nxt [NUM_CH];
  logic [EVT_W-1:0] acc_err_nxt[NUM_CH];
  logic [EVT_W-1:0] acc_oreq, acc_oreq_nxt;
  logic [EVT_W-1:0] acc_ook,  acc_ook_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LEN_W-1:0] b,
                                               input logic             en);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    if (!en)
      return a;
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] a,
                                               input logic             en);
    return (en && (a != '1)) ? a + EVT_W'(1) : a;
  endfunction

  // The trigger cycle is window index 0, so it is treated exactly like a RUN cycle.
  assign len_eff  = (cfg_window == 32'd0) ? 32'd1 : cfg_window;
  assign any_fire = (|tx_fire) | (|rx_fire) | open_req_fire;
  assign trig     = (state == WAIT_TRIG) && any_fire;
  assign active   = (state == RUN) || trig;
  assign cur_idx  = (state == RUN) ? win_cycle : 32'd0;
  assign cur_len  = (state == RUN) ? win_len : len_eff;
  assign win_last = active && (cur_idx == cur_len - 32'd1);
  assign count_en = active && cfg_en && !cfg_clear;
  assign win_end  = count_en && win_last;
  assign running  = (state == RUN);

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    if (cfg_clear)
      state_nxt = cfg_en ? WAIT_TRIG : IDLE;
    else if (!cfg_en)
      state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:      state_nxt = WAIT_TRIG;
        WAIT_TRIG: if (trig) state_nxt = (win_last && !cfg_mode) ? DONE : RUN;
        RUN:       if (win_last && !cfg_mode) state_nxt = DONE;
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_oreq_nxt = sat_inc(acc_oreq, open_req_fire);
    acc_ook_nxt  = sat_inc(acc_ook,  open_ok_fire);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      acc_tx_nxt[ch]  = sat_add(acc_tx[ch], tx_len[ch*LEN_W +: LEN_W], tx_fire[ch] & ~tx_err[ch]);
      acc_rx_nxt[ch]  = sat_add(acc_rx[ch], rx_len[ch*LEN_W +: LEN_W], rx_fire[ch]);
      acc_err_nxt[ch] = sat_inc(acc_err[ch], tx_fire[ch] & tx_err[ch]);
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (areset) begin
      state     <= IDLE;
      win_cycle <= 32'd0;
      win_len   <= 32'd1;
    end else begin
      state <= state_nxt;
      if (count_en && (trig || win_last))
        win_len <= len_eff;
      if (!count_en || win_end)
        win_cycle <= 32'd0;
      else if (trig)
        win_cycle <= 32'd1;
      else
        win_cycle <= win_cycle + 32'd1;
    end
  end

  // Accumulators only hold data while a window is open; anything else returns them to zero.
  always_ff @(posedge aclk) begin
    // NOTE: these arrays are plain flops (not RAM), so they take the reset like any register.
    if (areset || !count_en || win_end) begin
      acc_oreq <= '0;
      acc_ook  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc_tx[ch]  <= '0;
        acc_rx[ch]  <= '0;
        acc_err[ch] <= '0;
      end
    end else begin
      acc_oreq <= acc_oreq_nxt;
      acc_ook  <= acc_ook_nxt;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc_tx[ch]  <= acc_tx_nxt[ch];
        acc_rx[ch]  <= acc_rx_nxt[ch];
        acc_err[ch] <= acc_err_nxt[ch];
      end
    end
  end

  // Snapshot includes the last window cycle's own events via the *_nxt values.
  always_ff @(posedge aclk) begin
    if (areset || cfg_clear) begin
      snap_valid    <= 1'b0;
      snap_seq      <= 16'd0;
      snap_tx_bytes <= '0;
      snap_rx_bytes <= '0;
      snap_tx_err   <= '0;
      snap_open_req <= '0;
      snap_open_ok  <= '0;
    end else begin
      snap_valid <= win_end;
      if (win_end) begin
        snap_seq      <= snap_seq + 16'd1;
        snap_open_req <= acc_oreq_nxt;
        snap_open_ok  <= acc_ook_nxt;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          snap_tx_bytes[ch*CNT_W +: CNT_W] <= acc_tx_nxt[ch];
          snap_rx_bytes[ch*CNT_W +: CNT_W] <= acc_rx_nxt[ch];
          snap_tx_err[ch*EVT_W +: EVT_W]   <= acc_err_nxt[ch];
        end
      end
    end
  end

endmodule
